// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream beat, downstream head, flush and status.
// The slave modport is the skid register's view; master is the surrounding pipeline's view.
interface pipe_skid_reg_if #(
   parameter int DATA_W = 16,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              flush;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  drop_cnt;

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready, flush,
      output in_ready, out_valid, out_data, out_ctrl, occupancy, drop_cnt
   );

   modport master (
      output in_valid, in_data, in_ctrl, out_ready, flush,
      input  in_ready, out_valid, out_data, out_ctrl, occupancy, drop_cnt
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with registered in_ready, flush squash and a
// saturating count of beats discarded by flush.
module pipe_skid_reg #(
   parameter int DATA_W = 16,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 8
) (
   input logic           clk,
   input logic           rst,
   pipe_skid_reg_if.slave bus
);
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   localparam int SUM_W = CNT_W + 2;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   logic              accept;
   logic              fire;
   logic              head_valid;
   logic [1:0]        occ;
   logic [1:0]        drop_inc;
   logic [SUM_W-1:0]  drop_sum;
   logic [CNT_W-1:0]  drop_sat;

   assign occ        = state_q;
   assign head_valid = (state_q != S_EMPTY);
   assign accept     = bus.in_valid & in_ready_q;
   assign fire       = head_valid & bus.out_ready;

   // A beat that fires on the flush edge was taken downstream, so it is not a drop.
   // In FULL accept is impossible, so the increment never exceeds 2.
   assign drop_inc = occ + {1'b0, accept} - {1'b0, fire};
   assign drop_sum = {2'b00, drop_cnt_q} + {{CNT_W{1'b0}}, drop_inc};
   assign drop_sat = (drop_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                          : drop_sum[CNT_W-1:0];

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      drop_cnt_d  = drop_cnt_q;

      if (bus.flush) begin
         state_d    = S_EMPTY;
         drop_cnt_d = drop_sat;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  main_data_d = bus.in_data;
                  main_ctrl_d = bus.in_ctrl;
                  state_d     = S_ONE;
               end
            end
            S_ONE: begin
               if (accept && fire) begin
                  main_data_d = bus.in_data;
                  main_ctrl_d = bus.in_ctrl;
               end else if (accept) begin
                  skid_data_d = bus.in_data;
                  skid_ctrl_d = bus.in_ctrl;
                  state_d     = S_FULL;
               end else if (fire) begin
                  state_d = S_EMPTY;
               end
            end
            S_FULL: begin
               if (fire) begin
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  state_d     = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end

      // Ready is precomputed from the next state so out_ready never reaches in_ready.
      in_ready_d = (state_d != S_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= in_ready_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = head_valid;
   assign bus.out_data  = main_data_q;
   assign bus.out_ctrl  = head_valid ? main_ctrl_q : '0;
   assign bus.occupancy = occ;
   assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 16: payload width (ALU result, operands, PC+2, immediates), carried through unaltered.
REQ-002 Parameter CTRL_W, default 8: control-bit width (RegWrt, MemWrt, halt, branch, ...), forced to zero in bubbles.
REQ-003 Parameter CNT_W, default 8: width of the flush-drop counter.
REQ-004 clk  in  1  the single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-high.
REQ-006 in_valid  in  1  the upstream stage presents a beat.
REQ-007 in_ready  out  1  the block accepts a beat this cycle; driven from a register only.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 in_ctrl  in  CTRL_W  upstream control bits.
REQ-010 out_valid  out  1  the head entry is valid.
REQ-011 out_ready  in  1  downstream accepts the head; 0 = stall.
REQ-012 out_data  out  DATA_W  head payload.
REQ-013 out_ctrl  out  CTRL_W  head control bits; all zero whenever out_valid=0.
REQ-014 flush  in  1  synchronous squash of all held and incoming beats (branch taken / jump resolved).
REQ-015 occupancy  out  2  number of valid entries: 0, 1 or 2.
REQ-016 drop_cnt  out  CNT_W  saturating count of valid beats discarded by flush.

Function
REQ-017 Two storage entries: main (drives out_*) and skid; state EMPTY (0), ONE (1) or FULL (2); occupancy encodes the state.
REQ-018 Accept = in_valid & in_ready; fire = out_valid & out_ready; both are evaluated on the same edge.
REQ-019 in_ready = 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-020 EMPTY: accept -> main <= in, ONE; otherwise hold.
REQ-021 ONE: accept & fire -> main <= in, stay ONE; accept & !fire -> skid <= in, FULL; !accept & fire -> EMPTY; neither -> hold.
REQ-022 FULL: fire -> main <= skid, ONE; !fire -> hold both entries.
REQ-023 Latency: an accepted beat appears on out_* on the next cycle when the block was EMPTY, or when it was ONE with fire; full throughput is 1 beat/cycle.
REQ-024 Beats leave in acceptance order; no beat is duplicated or lost except by flush.
REQ-025 flush has priority over accept and fire: the next state is EMPTY, the in_* beat of that cycle is discarded, and out_valid=0 on the following cycle.
REQ-026 On flush, drop_cnt += occupancy + (in_valid & in_ready), saturating at 2^CNT_W-1; the counter never wraps.
REQ-027 A fire coinciding with flush still counts as taken downstream; that beat is excluded from the drop_cnt increment.
REQ-028 out_data holds its last value when out_valid=0; only out_ctrl is zeroed.
REQ-029 Control bits are never altered in flight; no per-bit decoding.

Reset
REQ-030 While rst is high: state EMPTY, out_valid=0, in_ready=0, occupancy=0, out_data=0, out_ctrl=0, skid=0, drop_cnt=0; these take effect immediately, without a clock edge.
REQ-031 in_ready rises on the first clock edge after rst deasserts.
REQ-032 Reset asserted mid-operation discards all entries without incrementing drop_cnt.

Verification
REQ-033 Stream: out_ready=1, in_valid=1 with in_data 0x0001..0x0010 -> out_data 0x0001..0x0010 on consecutive cycles, 1-cycle latency, occupancy steady at 1.
REQ-034 Stall: out_ready=0 while 3 beats (0xAAAA, 0xBBBB, 0xCCCC) are offered -> first two accepted, occupancy=2, in_ready=0, 0xCCCC held upstream; out_ready=1 -> 0xAAAA, 0xBBBB, 0xCCCC delivered in order.
REQ-035 Flush while FULL with in_valid=0 -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0, drop_cnt=2.
REQ-036 Flush with FULL (in_valid=1, no accept possible) vs. ONE (in_valid=1, accepted) -> drop_cnt increments by 2 in both cases, and the ONE-state incoming beat never appears on out_*.
REQ-037 Saturation: CNT_W=2, three flushes each dropping 2 -> drop_cnt=3, held at 3 on a further flush.
REQ-038 Async reset pulse between clock edges while FULL -> outputs zero immediately, drop_cnt unchanged from 0 after reset, in_ready=1 after the next edge.
